// File: rtl/soc_event_bridge_pkg.sv
// Shared types and one-hot helpers for the SoC-to-cluster event bridge.
// The helpers work on a fixed maximum width so that any ring size up to MAX_SLOTS can use them.
package soc_event_bridge_pkg;

  localparam int unsigned EVT_W     = 8;
  localparam int unsigned MAX_SLOTS = 64;

  typedef logic [EVT_W-1:0]             evt_t;
  typedef logic [MAX_SLOTS-1:0]         slot_vec_t;
  typedef logic [$clog2(MAX_SLOTS)-1:0] slot_idx_t;

  // Rotate the low 'width' bits of v left by one; bit width-1 wraps to bit 0.
  function automatic slot_vec_t onehot_rotl(slot_vec_t v, int unsigned width);
    slot_vec_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_SLOTS - 1; i++) begin
      if (i + 1 < width) r[i+1] = v[i];
    end
    for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
      if (i + 1 == width) r[0] = v[i];
    end
    return r;
  endfunction

  function automatic slot_idx_t onehot2idx(slot_vec_t v);
    slot_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
      if (v[i]) idx = idx | slot_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer,
// then moves the pointer just past the winner.
module soc_evt_rr_arb #(
  parameter int unsigned NB_CHANNELS = 4,
  parameter int unsigned IDX_W       = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NB_CHANNELS-1:0] req_i,
  input  logic                   adv_i,
  output logic [NB_CHANNELS-1:0] gnt_o,
  output logic [IDX_W-1:0]       gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      cand;
  int unsigned      nxt;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NB_CHANNELS) cand = cand - NB_CHANNELS;
      if (!found && adv_i && req_i[IDX_W'(cand)]) begin
        found                  = 1'b1;
        gnt_o[IDX_W'(cand)]    = 1'b1;
        gnt_idx_o              = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    nxt   = 32'(gnt_idx_o) + 1;
    ptr_d = ptr_q;
    if (found) ptr_d = (nxt >= NB_CHANNELS) ? '0 : IDX_W'(nxt);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/soc_event_bridge.sv
// Merges NB_CHANNELS event sources into a one-hot-token ring buffer read by the cluster
// event unit, with per-channel enable, drop-on-full mode and saturating drop counters.
module soc_event_bridge
  import soc_event_bridge_pkg::*;
#(
  parameter int unsigned NB_CHANNELS  = 4,
  parameter int unsigned EVNT_WIDTH   = 8,
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned LVL_WIDTH    = $clog2(BUFFER_WIDTH)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NB_CHANNELS-1:0]             evt_valid_i,
  input  logic [NB_CHANNELS*EVNT_WIDTH-1:0]  evt_data_i,
  output logic [NB_CHANNELS-1:0]             evt_ack_o,
  input  logic [NB_CHANNELS-1:0]             chan_en_i,
  input  logic                               drop_mode_i,
  input  logic                               cnt_clr_i,
  output logic [BUFFER_WIDTH-1:0]            events_wt_o,
  input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
  output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
  output logic [LVL_WIDTH-1:0]               level_o,
  output logic [NB_CHANNELS*CNT_WIDTH-1:0]   drop_cnt_o,
  output logic                               full_o
);

  localparam int unsigned CH_W   = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;
  localparam int unsigned SLOT_W = $clog2(BUFFER_WIDTH);

  logic [BUFFER_WIDTH-1:0]                  wt_q, wt_d, wt_rot;
  logic [BUFFER_WIDTH-1:0][EVNT_WIDTH-1:0]  slot_q;
  logic [NB_CHANNELS-1:0][CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NB_CHANNELS-1:0][EVNT_WIDTH-1:0]   data_arr;
  slot_vec_t                                wt_ext, rp_ext, rot_ext;
  slot_idx_t                                wt_idx, rp_idx;
  logic [SLOT_W-1:0]                        wr_idx;
  logic [NB_CHANNELS-1:0]                   req, gnt;
  logic [CH_W-1:0]                          gnt_idx;
  logic                                     full, adv, do_write, do_drop;
  int                                       lvl;

  assign data_arr = evt_data_i;

  always_comb begin
    wt_ext                    = '0;
    rp_ext                    = '0;
    wt_ext[BUFFER_WIDTH-1:0]  = wt_q;
    rp_ext[BUFFER_WIDTH-1:0]  = events_rp_i;
    rot_ext                   = onehot_rotl(wt_ext, BUFFER_WIDTH);
    wt_rot                    = rot_ext[BUFFER_WIDTH-1:0];
    wt_idx                    = onehot2idx(wt_ext);
    rp_idx                    = onehot2idx(rp_ext);
    wr_idx                    = SLOT_W'(wt_idx);
  end

  // One slot is always left empty so that full and empty stay distinguishable.
  assign full = (wt_rot == events_rp_i);

  always_comb begin
    lvl = int'(wt_idx) - int'(rp_idx);
    if (lvl < 0) lvl = lvl + int'(BUFFER_WIDTH);
  end

  assign req = evt_valid_i & chan_en_i;
  assign adv = ~full | drop_mode_i;

  soc_evt_rr_arb #(
    .NB_CHANNELS (NB_CHANNELS),
    .IDX_W       (CH_W)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req),
    .adv_i     (adv),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign do_write = (|gnt) & ~full;
  assign do_drop  = (|gnt) & full;
  assign wt_d     = do_write ? wt_rot : wt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (do_drop && (cnt_q[gnt_idx] != '1)) begin
      cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNT_WIDTH'(1);
    end
  end

  // NOTE: slot storage is reset too, because the consumer may sample events_da_o straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wt_q   <= BUFFER_WIDTH'(1);
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      wt_q  <= wt_d;
      cnt_q <= cnt_d;
      if (do_write) slot_q[wr_idx] <= data_arr[gnt_idx];
    end
  end

  // Ack is masked by reset directly so it falls without waiting for a clock edge.
  assign evt_ack_o   = rst_i ? '0 : gnt;
  assign events_wt_o = wt_q;
  assign events_da_o = slot_q;
  assign drop_cnt_o  = cnt_q;
  assign full_o      = full;
  assign level_o     = LVL_WIDTH'(lvl);

  rp_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i) $onehot(events_rp_i));

endmodule

// File: tb/tb_soc_event_bridge.sv
// Self-checking bench for soc_event_bridge: a small behavioural model predicts acks, level,
// full and drop counters; accepted writes are queued and compared once the slot is visible.
module tb_soc_event_bridge;
  import soc_event_bridge_pkg::*;

  localparam int NB = 4;
  localparam int EW = 8;
  localparam int BW = 8;
  localparam int CW = 8;
  localparam int LW = 3;

  logic              clk;
  logic              rst;
  logic [NB-1:0]     valid, en, ack;
  logic [NB*EW-1:0]  evt_data;
  logic              drop, clr;
  logic [BW-1:0]     wt, rp;
  logic [BW*EW-1:0]  da;
  logic [LW-1:0]     level;
  logic [NB*CW-1:0]  cnt;
  logic              full;

  evt_t data_arr [NB];
  int   rp_idx;

  soc_event_bridge #(
    .NB_CHANNELS  (NB),
    .EVNT_WIDTH   (EW),
    .BUFFER_WIDTH (BW),
    .CNT_WIDTH    (CW),
    .LVL_WIDTH    (LW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .evt_valid_i (valid),
    .evt_data_i  (evt_data),
    .evt_ack_o   (ack),
    .chan_en_i   (en),
    .drop_mode_i (drop),
    .cnt_clr_i   (clr),
    .events_wt_o (wt),
    .events_rp_i (rp),
    .events_da_o (da),
    .level_o     (level),
    .drop_cnt_o  (cnt),
    .full_o      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    evt_data = '0;
    for (int c = 0; c < NB; c++) evt_data[c*EW +: EW] = data_arr[c];
  end
  assign rp = BW'(1) << rp_idx;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    int   slot;
    evt_t data;
  } wr_t;

  wr_t           sb [$];
  int            m_wt, m_ptr, last_g;
  int            m_cnt [NB];
  logic [NB-1:0] ack_seen;

  task automatic model_reset();
    m_wt  = 0;
    m_ptr = 0;
    for (int c = 0; c < NB; c++) m_cnt[c] = 0;
    sb.delete();
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    int            g;
    int            c;
    logic          m_full;
    logic [NB-1:0] exp_ack;
    wr_t           e;
    #1;
    m_full = ((m_wt + 1) % BW == rp_idx);
    g = -1;
    if (!m_full || drop) begin
      for (int i = 0; i < NB; i++) begin
        c = (m_ptr + i) % NB;
        if (g < 0 && valid[c] && en[c]) g = c;
      end
    end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    check("ack", ack, exp_ack);
    check("full", full, m_full);
    check("level", level, (m_wt - rp_idx + BW) % BW);
    ack_seen = ack_seen | ack;
    last_g   = g;
    if (g >= 0) begin
      if (!m_full) begin
        sb.push_back('{slot: m_wt, data: data_arr[g]});
        m_wt = (m_wt + 1) % BW;
      end else if (m_cnt[g] < (1 << CW) - 1) begin
        m_cnt[g]++;
      end
      m_ptr = (g + 1) % NB;
    end
    if (clr) for (int k = 0; k < NB; k++) m_cnt[k] = 0;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("slot_data", da[e.slot*EW +: EW], e.data);
    end
    check("wt", wt, 64'(1) << m_wt);
    for (int k = 0; k < NB; k++) check("drop_cnt", cnt[k*CW +: CW], m_cnt[k]);
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    valid    = '1;
    en       = '1;
    drop     = 1'b0;
    clr      = 1'b0;
    rp_idx   = 0;
    ack_seen = '0;
    last_g   = -1;
    for (int c = 0; c < NB; c++) data_arr[c] = '0;
    model_reset();

    // Reset state, with every channel requesting.
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_wt", wt, 1);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_da", da, 0);
    check("rst_cnt", cnt, 0);
    rst   = 1'b0;
    valid = '0;

    // Single write from channel 1.
    @(negedge clk);
    valid       = 4'b0010;
    data_arr[1] = 8'hA5;
    cycle();
    check("first_slot0", da[7:0], 8'hA5);
    check("first_wt", wt, 8'h02);
    check("first_level", level, 1);
    valid = '0;

    // Round-robin fairness with the consumer keeping up; pointer sits at channel 2.
    for (int c = 0; c < NB; c++) data_arr[c] = EW'(16 + c);
    valid = '1;
    for (int i = 0; i < 8; i++) begin
      rp_idx = m_wt;
      cycle();
      check("rr_order", last_g, (2 + i) % NB);
    end
    valid = '0;

    // Full back-pressure from a clean ring.
    rst = 1'b1;
    #1;
    model_reset();
    rp_idx = 0;
    @(negedge clk);
    rst   = 1'b0;
    valid = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      data_arr[0] = EW'(8'h30 + k);
      cycle();
    end
    check("bp_full", full, 1);
    check("bp_wt", wt, 8'h80);
    check("bp_level", level, 7);
    data_arr[0] = 8'h37;
    repeat (3) cycle();
    check("bp_held_wt", wt, 8'h80);
    rp_idx = 1;
    cycle();
    check("bp_release", last_g, 0);

    // Drop mode on a full ring, then saturation and clear.
    valid       = 4'b0100;
    data_arr[2] = 8'hEE;
    drop        = 1'b1;
    repeat (3) cycle();
    check("drop_three", cnt[2*CW +: CW], 3);
    check("drop_wt", wt, 8'h01);
    repeat (255) cycle();
    check("drop_sat", cnt[2*CW +: CW], 255);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("drop_clr", cnt[2*CW +: CW], 0);
    valid = '0;
    drop  = 1'b0;

    // Channel 2 disabled, twenty writes wrapping the token twice.
    en       = 4'b1011;
    valid    = '1;
    ack_seen = '0;
    for (int c = 0; c < NB; c++) data_arr[c] = EW'(8'h40 + c);
    for (int k = 0; k < 20; k++) begin
      rp_idx = m_wt;
      cycle();
      if (last_g >= 0) data_arr[last_g] = data_arr[last_g] + 8'h11;
    end
    check("ch2_never", ack_seen[2], 0);
    check("wrap_wt", wt, 8'h10);

    // Asynchronous reset between clock edges.
    en     = '1;
    valid  = 4'b0001;
    rp_idx = m_wt;
    #1;
    check("pre_rst_ack", ack[0], 1);
    #2;
    rst    = 1'b1;
    rp_idx = 0;
    #1;
    check("arst_ack", ack, 0);
    check("arst_wt", wt, 1);
    check("arst_level", level, 0);
    check("arst_da", da, 0);
    model_reset();
    @(negedge clk);
    rst   = 1'b0;
    valid = '0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
